// File: rtl/c16_pkg.sv
// c16_pkg: shared c16 op codes, register constants and mem_stage state encoding
package c16_pkg;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_NOP = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h4;
    localparam logic [3:0] OP_BRZ = 4'h5;
    localparam logic [3:0] OP_SUB = 4'hf;
    localparam logic [2:0] REG_R7 = 3'd7;
    typedef enum logic {ST_IDLE, ST_WAIT} mem_state_t;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts WAIT cycles without ack and flags the TIMEOUT-th one
module mem_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    assign o_expire = i_enable && (r_cnt == CW'(TIMEOUT - 1));
    // count unacknowledged WAIT cycles since the access was issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_enable) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: c16 memory-access stage; optional WAIT timeout under C16_MEM_TIMEOUT_EN
module mem_stage
    import c16_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_dest,
    input  logic [DATA_W-1:0] in_value,
    input  logic [DATA_W-1:0] in_store_data,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              wb_enable,
    output logic [2:0]        wb_dest,
    output logic [DATA_W-1:0] wb_value,
    output logic              mem_err
);
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT must be at least 1");
    end

    mem_state_t        r_state, w_next;
    logic              r_we, r_wb_en;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_wb_value;
    logic [2:0]        r_dest, r_wb_dest;
    logic              w_wait, w_issue, w_alu, w_expire;

    assign w_wait  = r_state == ST_WAIT;
    assign w_alu   = in_op == OP_ADD || in_op == OP_SUB;
    assign w_issue = !w_wait && in_valid && (in_op == OP_LD || in_op == OP_ST);

    // stall and request follow the state directly so reset drops them at once
    assign stall     = w_wait;
    assign mem_req   = w_wait;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign wb_enable = r_wb_en;
    assign wb_dest   = r_wb_dest;
    assign wb_value  = r_wb_value;

`ifdef C16_MEM_TIMEOUT_EN
    logic r_err;
    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_issue),
        .i_enable (w_wait && !mem_ack),
        .o_expire (w_expire)
    );
    assign mem_err = r_err;
    // one-cycle abort pulse when the watchdog ends an unacknowledged access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else r_err <= w_expire;
    end
`else
    assign w_expire = 1'b0;
    assign mem_err  = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    // IDLE issues LD/ST into WAIT; ack (or watchdog expiry) returns to IDLE
    always_comb begin
        w_next = r_state;
        if (w_issue) w_next = ST_WAIT;
        else if (w_wait && (mem_ack || w_expire)) w_next = ST_IDLE;
    end

    // request capture and single-cycle writeback for ALU results and loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dest     <= '0;
            r_wb_en    <= 1'b0;
            r_wb_dest  <= '0;
            r_wb_value <= '0;
        end else begin
            r_wb_en <= 1'b0;
            if (w_issue) begin
                r_we    <= in_op == OP_ST;
                r_addr  <= ADDR_W'(in_value);
                r_wdata <= in_store_data;
                r_dest  <= in_dest;
            end
            if (!w_wait && in_valid && w_alu) begin
                r_wb_en    <= in_dest != REG_R7;
                r_wb_dest  <= in_dest;
                r_wb_value <= in_value;
            end
            if (w_wait && mem_ack && !r_we) begin
                r_wb_en    <= r_dest != REG_R7;
                r_wb_dest  <= r_dest;
                r_wb_value <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against per-instruction rules
module tb_mem_stage;
    import c16_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [2:0]  in_dest;
    logic [15:0] in_value, in_store_data, mem_rdata;
    logic        mem_ack;
    logic        stall, mem_req, mem_we, wb_enable, mem_err;
    logic [15:0] mem_addr, mem_wdata, wb_value;
    logic [2:0]  wb_dest;
    int checks = 0;
    int errors = 0;

    mem_stage #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_dest(in_dest),
        .in_value(in_value), .in_store_data(in_store_data), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_enable(wb_enable),
        .wb_dest(wb_dest), .wb_value(wb_value), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] d,
                         input logic [15:0] val, input logic [15:0] sd);
        in_valid      = v;
        in_op         = op;
        in_dest       = d;
        in_value      = val;
        in_store_data = sd;
    endtask

    logic [3:0] ops [7];
    initial begin
        logic        v, is_alu, is_mem, exp_wb;
        logic [3:0]  op;
        logic [2:0]  d;
        logic [15:0] val, sd, rd;
        int          n, cyc;
        ops = '{OP_ADD, OP_SUB, OP_NOP, OP_BRZ, OP_LD, OP_ST, 4'h9};
        rst = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(1'b0, OP_NOP, 3'd0, 16'h0, 16'h0);
        step();
        step();
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wb_en", wb_enable, 0);
        chk("rst_wb_dest", wb_dest, 0);
        chk("rst_wb_value", wb_value, 0);
        chk("rst_err", mem_err, 0);
        rst = 1'b0;
        step();

        drive(1'b1, OP_ADD, 3'd3, 16'h1234, 16'h0);
        chk("add_stall_pre", stall, 0);
        step();
        chk("add_wb_en", wb_enable, 1);
        chk("add_wb_dest", wb_dest, 3);
        chk("add_wb_value", wb_value, 16'h1234);
        chk("add_stall", stall, 0);
        drive(1'b1, OP_ADD, 3'd7, 16'h4444, 16'h0);
        step();
        chk("add_r7_wb_en", wb_enable, 0);
        drive(1'b1, OP_BRZ, 3'd2, 16'h5555, 16'h0);
        step();
        chk("brz_wb_en", wb_enable, 0);
        drive(1'b0, OP_NOP, 3'd0, 16'h0, 16'h0);
        step();
        chk("idle_wb_en", wb_enable, 0);

        drive(1'b1, OP_LD, 3'd4, 16'h0040, 16'h0);
        step();
        drive(1'b1, OP_ADD, 3'd5, 16'h5A5A, 16'h0);
        for (int k = 0; k < 3; k++) begin
            chk("ld_req", mem_req, 1);
            chk("ld_addr", mem_addr, 16'h0040);
            chk("ld_we", mem_we, 0);
            chk("ld_stall", stall, 1);
            chk("ld_wait_wb_en", wb_enable, 0);
            if (k == 2) begin
                mem_ack = 1'b1;
                mem_rdata = 16'hBEEF;
            end
            step();
        end
        mem_ack = 1'b0;
        chk("ld_wb_en", wb_enable, 1);
        chk("ld_wb_dest", wb_dest, 4);
        chk("ld_wb_value", wb_value, 16'hBEEF);
        chk("ld_req_drop", mem_req, 0);
        chk("ld_stall_drop", stall, 0);
        step();
        chk("held_add_wb_en", wb_enable, 1);
        chk("held_add_wb_dest", wb_dest, 5);
        chk("held_add_wb_value", wb_value, 16'h5A5A);
        drive(1'b0, OP_NOP, 3'd0, 16'h0, 16'h0);
        step();

        drive(1'b1, OP_ST, 3'd1, 16'h0010, 16'h00AA);
        step();
        drive(1'b0, OP_NOP, 3'd0, 16'h0, 16'h0);
        chk("st_req", mem_req, 1);
        chk("st_we", mem_we, 1);
        chk("st_addr", mem_addr, 16'h0010);
        chk("st_wdata", mem_wdata, 16'h00AA);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_wb_en", wb_enable, 0);
        chk("st_req_drop", mem_req, 0);
        step();
        chk("st_wb_en_after", wb_enable, 0);

        drive(1'b1, OP_LD, 3'd2, 16'h0077, 16'h0);
        step();
        drive(1'b0, OP_NOP, 3'd0, 16'h0, 16'h0);
        chk("rstw_stall_pre", stall, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstw_req", mem_req, 0);
        chk("rstw_stall", stall, 0);
        chk("rstw_wb_en", wb_enable, 0);
        step();
        rst = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'hCAFE;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_wb_en", wb_enable, 0);
        chk("idle_ack_req", mem_req, 0);

`ifdef C16_MEM_TIMEOUT_EN
        drive(1'b1, OP_LD, 3'd3, 16'h0100, 16'h0);
        step();
        drive(1'b0, OP_NOP, 3'd0, 16'h0, 16'h0);
        cyc = 0;
        while (mem_req && cyc < 40) begin
            chk("to_err_low", mem_err, 0);
            cyc++;
            step();
        end
        chk("to_req_cycles", cyc, 15);
        chk("to_err", mem_err, 1);
        chk("to_stall", stall, 0);
        chk("to_wb_en", wb_enable, 0);
        step();
        chk("to_err_pulse", mem_err, 0);
        chk("to_wb_en_after", wb_enable, 0);
        drive(1'b1, OP_LD, 3'd6, 16'h0200, 16'h0);
        step();
        drive(1'b0, OP_NOP, 3'd0, 16'h0, 16'h0);
        for (int k = 0; k < 15; k++) begin
            if (k == 14) begin
                mem_ack = 1'b1;
                mem_rdata = 16'h1357;
            end
            step();
        end
        mem_ack = 1'b0;
        chk("to_ack_err", mem_err, 0);
        chk("to_ack_wb_en", wb_enable, 1);
        chk("to_ack_wb_value", wb_value, 16'h1357);
`else
        drive(1'b1, OP_LD, 3'd3, 16'h0100, 16'h0);
        step();
        drive(1'b0, OP_NOP, 3'd0, 16'h0, 16'h0);
        repeat (40) step();
        chk("long_wait_req", mem_req, 1);
        chk("long_wait_stall", stall, 1);
        chk("long_wait_err", mem_err, 0);
        mem_ack = 1'b1;
        mem_rdata = 16'h1357;
        step();
        mem_ack = 1'b0;
        chk("long_wait_wb_en", wb_enable, 1);
        chk("long_wait_wb_value", wb_value, 16'h1357);
`endif
        step();

        for (int i = 0; i < 80; i++) begin
            v  = $urandom_range(0, 4) != 0;
            op = ops[$urandom_range(0, 6)];
            d  = 3'($urandom_range(0, 7));
            val = 16'($urandom);
            sd  = 16'($urandom);
            is_alu = op == OP_ADD || op == OP_SUB;
            is_mem = op == OP_LD || op == OP_ST;
            mem_ack = $urandom_range(0, 3) == 0;
            mem_rdata = 16'($urandom);
            drive(v, op, d, val, sd);
            step();
            mem_ack = 1'b0;
            if (v && is_alu) begin
                chk("r_alu_wb_en", wb_enable, d != 3'd7);
                if (d != 3'd7) begin
                    chk("r_alu_wb_dest", wb_dest, d);
                    chk("r_alu_wb_value", wb_value, val);
                end
                chk("r_alu_stall", stall, 0);
            end else if (v && is_mem) begin
                chk("r_mem_wb_en", wb_enable, 0);
                n = $urandom_range(0, 4);
                for (int j = 0; j <= n; j++) begin
                    chk("r_mem_req", mem_req, 1);
                    chk("r_mem_stall", stall, 1);
                    chk("r_mem_addr", mem_addr, val);
                    chk("r_mem_we", mem_we, op == OP_ST);
                    if (op == OP_ST) chk("r_mem_wdata", mem_wdata, sd);
                    if (j == n) begin
                        mem_ack = 1'b1;
                        rd = 16'($urandom);
                        mem_rdata = rd;
                        in_valid = 1'b0;
                    end
                    step();
                end
                mem_ack = 1'b0;
                exp_wb = op == OP_LD && d != 3'd7;
                chk("r_mem_done_req", mem_req, 0);
                chk("r_mem_done_err", mem_err, 0);
                chk("r_mem_wb_en_done", wb_enable, exp_wb);
                if (exp_wb) begin
                    chk("r_ld_wb_dest", wb_dest, d);
                    chk("r_ld_wb_value", wb_value, rd);
                end
            end else begin
                chk("r_other_wb_en", wb_enable, 0);
                chk("r_other_stall", stall, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the c16 pipeline, placed directly downstream of the execute stage and upstream of the register file write port. It passes ALU results (ADD/SUB) through to writeback with one register of latency. It performs LD/ST against an external data memory through a req/ack handshake. While a memory access is outstanding it stalls the execute stage.

## Interface
Parameters:
- DATA_W, 16, datapath width
- ADDR_W, 16, data-memory address width
- TIMEOUT, 15, max WAIT cycles before abort (used only with the timeout feature)

Ports:
- clk  in  1  single pipeline clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute-stage result valid this cycle
- in_op  in  4  op code: ADD=4'h0, NOP=4'h2, LD=4'h3, ST=4'h4, BRZ=4'h5, SUB=4'hf
- in_dest  in  3  destination register index
- in_value  in  DATA_W  ALU result (ADD/SUB) or effective address (LD/ST)
- in_store_data  in  DATA_W  store operand (ST only)
- stall  out  1  execute stage must hold its outputs
- mem_req  out  1  memory request
- mem_we  out  1  1=store, 0=load
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- mem_ack  in  1  memory completes request
- wb_enable  out  1  register-file write enable
- wb_dest  out  3  register-file write address
- wb_value  out  DATA_W  register-file write data
- mem_err  out  1  one-cycle abort pulse

Clock and reset are fixed: a single clock `clk`, and `rst` is asynchronous and active-high.

## Operation
- FSM states: IDLE and WAIT. Reset drives state to IDLE.
- Reset values: all outputs are 0 (stall, mem_req, mem_we, mem_addr, mem_wdata, wb_*, mem_err).
- IDLE, in_valid with ADD/SUB:
  - wb_enable=1, wb_dest=in_dest, wb_value=in_value on the next cycle.
  - Exception: in_dest==7 gives wb_enable=0, since r7 is not writable.
- IDLE, in_valid with NOP/BRZ/unknown op: wb_enable=0 next cycle.
- IDLE, in_valid with LD/ST:
  - At the edge, capture into the request registers: mem_addr=in_value[ADDR_W-1:0], mem_we=(op==ST), mem_wdata=in_store_data, dest.
  - Set mem_req=1 and enter WAIT. wb_enable=0 next cycle.
- WAIT:
  - stall=1. mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Upstream holds the following instruction and does not consume it.
- WAIT with mem_ack=1:
  - At the edge, mem_req drops to 0 and state returns to IDLE.
  - LD: wb_enable=1 (0 if dest==7), wb_value=mem_rdata sampled at that edge.
  - ST: no writeback.
- mem_ack while in IDLE is ignored.
- in_valid=0 in IDLE: wb_enable=0 next cycle.
- Arithmetic: none in the datapath. The address is truncated or zero-extended to ADDR_W.

## Timing
- ALU ops: 1-cycle latency from input to wb_*.
- wb_enable is a single-cycle pulse per instruction.
- LD: writeback appears on the cycle after the cycle where mem_ack=1.
- Minimum LD/ST occupancy is 2 cycles (accept cycle, then a WAIT cycle with ack). The held instruction is accepted on the cycle after ack, giving one bubble.
- stall is combinational from state (stall = state==WAIT) and never depends on mem_ack.
- Reset asserted mid-WAIT: mem_req and stall drop immediately (asynchronously). No writeback occurs; the pending access is discarded.

## Configuration
- Macro: C16_MEM_TIMEOUT_EN.
- Defined:
  - A WAIT-cycle counter clears on entry to WAIT and increments on each WAIT cycle without ack.
  - If ack is absent for TIMEOUT consecutive WAIT cycles, then at the end of the TIMEOUT-th cycle: mem_req drops, state goes to IDLE, mem_err pulses for 1 cycle, and there is no writeback.
  - If ack arrives on the TIMEOUT-th cycle, the ack wins and mem_err stays 0.
- Undefined: WAIT lasts indefinitely, no counter logic is built, and mem_err is tied 0.

## Structure
- Shared package c16_pkg holds:
  - op code constants (ADD, SUB, NOP, BRZ, LD, ST), also used by the decode and execute stages;
  - the mem_stage state enum;
  - the register-index constant for r7.
- One sub-module, mem_watchdog: TIMEOUT counter with clear/enable inputs and an expire output. It is instantiated only under C16_MEM_TIMEOUT_EN.

## Test plan
- ADD, dest=3, value=0x1234 -> next cycle wb_enable=1, wb_dest=3, wb_value=0x1234, stall=0 throughout.
- ADD with dest=7, and BRZ with dest=2 -> wb_enable stays 0 on both following cycles.
- LD at addr 0x0040, mem_ack on the 3rd WAIT cycle with rdata=0xBEEF:
  - mem_req=1 with addr 0x0040 and we=0 held for 3 cycles; stall=1 for the same 3 cycles;
  - next cycle wb_enable=1, wb_value=0xBEEF;
  - held ADD is accepted the cycle after.
- ST at addr 0x0010, data 0x00AA, immediate ack -> mem_we=1, mem_wdata=0x00AA for 1 WAIT cycle; no wb_enable.
- rst raised during WAIT of an LD -> mem_req, stall and wb_enable are 0 in the same cycle; a later ack in IDLE causes no writeback.
- With C16_MEM_TIMEOUT_EN and TIMEOUT=15, LD never acked -> mem_req high for exactly 15 cycles, then mem_err=1 for one cycle, state IDLE, no writeback.
